// File: rtl/shift_seq_pkg.sv
// ============================================================================
// Module : shift_seq_pkg
// Brief  : Shared op encodings and FSM state type for shift_seq_unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_seq_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_seq_unit_mux4_1.sv
// ============================================================================
// Module : mux4_1
// Brief  : 1-bit 4:1 combinational multiplexer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_1 (
  input  logic       i_d0,
  input  logic       i_d1,
  input  logic       i_d2,
  input  logic       i_d3,
  input  logic [1:0] i_sel,
  output logic       o_y
);

  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'd0:    o_y = i_d0;
      2'd1:    o_y = i_d1;
      2'd2:    o_y = i_d2;
      2'd3:    o_y = i_d3;
      default: o_y = i_d0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_seq_unit.sv
// ============================================================================
// Module : shift_seq_unit
// Brief  : Iterative SLL/SRL/SRA/ROL shifter with valid/ready handshake.
//          Define SHIFT_FAST_EN for a single-cycle log-shifter datapath.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq_unit
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [1:0]                 in_op,
  input  logic [$clog2(WIDTH)-1:0]   in_amt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       busy
);

  localparam int AW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [1:0]       r_op;
  logic [AW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_step;
  logic             w_accept;

  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_data  = r_work;

`ifdef SHIFT_FAST_EN
  // Stage s shifts by 2**s when bit s of the amount is set.
  logic [AW:0][WIDTH-1:0] w_stg;
  assign w_stg[0] = in_data;

  for (genvar s = 0; s < AW; s++) begin : g_stage
    localparam int SH = 2 ** s;
    logic [WIDTH-1:0] w_sll, w_srl, w_sra, w_rol;
    assign w_sll = w_stg[s] << SH;
    assign w_srl = w_stg[s] >> SH;
    assign w_sra = $signed(w_stg[s]) >>> SH;
    assign w_rol = (w_stg[s] << SH) | (w_stg[s] >> (WIDTH - SH));
    assign w_stg[s+1] = !in_amt[s]        ? w_stg[s] :
                        (in_op == OP_SLL) ? w_sll    :
                        (in_op == OP_SRL) ? w_srl    :
                        (in_op == OP_SRA) ? w_sra    : w_rol;
  end

  assign w_load = w_stg[AW];
  assign w_step = r_work;
`else
  assign w_load = in_data;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_lo, w_hi, w_sra_hi, w_rol_lo;
    if (i == 0) begin : g_lsb
      assign w_lo     = 1'b0;
      assign w_rol_lo = r_work[WIDTH-1];
    end else begin : g_mid_lo
      assign w_lo     = r_work[i-1];
      assign w_rol_lo = r_work[i-1];
    end
    if (i == WIDTH - 1) begin : g_msb
      assign w_hi     = 1'b0;
      assign w_sra_hi = r_work[WIDTH-1];
    end else begin : g_mid_hi
      assign w_hi     = r_work[i+1];
      assign w_sra_hi = r_work[i+1];
    end
    mux4_1 u_mux (
      .i_d0  (w_lo),
      .i_d1  (w_hi),
      .i_d2  (w_sra_hi),
      .i_d3  (w_rol_lo),
      .i_sel (r_op),
      .o_y   (w_step[i])
    );
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
`ifdef SHIFT_FAST_EN
          w_state_nxt = ST_DONE;
`else
          w_state_nxt = (in_amt != '0) ? ST_SHIFT : ST_DONE;
`endif
        end
      end
      ST_SHIFT: if (r_cnt == AW'(1)) w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_op    <= OP_SLL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_work <= w_load;
        r_op   <= in_op;
        r_cnt  <= in_amt;
      end else if (r_state == ST_SHIFT) begin
        r_work <= w_step;
        r_cnt  <= r_cnt - AW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_seq_unit.sv
// ============================================================================
// Module : tb_shift_seq_unit
// Brief  : Directed self-checking bench for shift_seq_unit (WIDTH=8).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_seq_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_op;
  logic [2:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int total = 0;
  int bad   = 0;

  shift_seq_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input int amt);
`ifdef SHIFT_FAST_EN
    return 0;
`else
    return amt;
`endif
  endfunction

  // Accept one request, wait for the result, check it, then hand it off.
  task automatic run(input string tag, input logic [7:0] d, input logic [1:0] op,
                     input logic [2:0] amt, input logic [7:0] exp, input bit noisy);
    int lat;
    in_valid = 1'b1; in_data = d; in_op = op; in_amt = amt;
    step();
    in_valid = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (noisy) begin
        in_valid  = 1'b1;
        in_data   = 8'($urandom);
        in_op     = 2'($urandom);
        in_amt    = 3'($urandom);
        out_ready = 1'b1;
      end
      step();
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_lat"}, lat, exp_lat(amt));
    chk({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, in_ready, 1'b1);
    chk({tag, "_idle_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0; in_amt = '0; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    step(); step();
    rst_n = 1'b1;
    step();

    run("sra96", 8'h96, 2'b10, 3'd3, 8'hF2, 1'b0);
    run("rol81", 8'h81, 2'b11, 3'd4, 8'h18, 1'b0);
    run("srl80", 8'h80, 2'b01, 3'd7, 8'h01, 1'b0);
    run("amt0_sll", 8'h5A, 2'b00, 3'd0, 8'h5A, 1'b0);
    run("amt0_rol", 8'h5A, 2'b11, 3'd0, 8'h5A, 1'b0);
    run("noisy_sll", 8'h0F, 2'b00, 3'd5, 8'hE0, 1'b1);
    chk("noisy_no_second", out_valid, 1'b0);
    step();
    chk("noisy_no_second2", out_valid, 1'b0);
    chk("noisy_no_busy", busy, 1'b0);

    // Stall in DONE with out_ready low.
    in_valid = 1'b1; in_data = 8'h3C; in_op = 2'b00; in_amt = 3'd2;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) step();
    chk("hold_data0", out_data, 8'hF0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_data", out_data, 8'hF0);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hold_release_ready", in_ready, 1'b1);

    // Asynchronous reset in the middle of an operation.
    in_valid = 1'b1; in_data = 8'h81; in_op = 2'b00; in_amt = 3'd6;
    step();
    in_valid = 1'b0;
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_out_data", out_data, 8'h00);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_ready", in_ready, 1'b1);
    run("sll81_after_rst", 8'h81, 2'b00, 3'd1, 8'h02, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_seq_unit.md
SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width; it must be a power of two and at least 2.
REQ-002 The block SHALL have derived localparam AW = log2(WIDTH), giving the shift-amount width (3 when WIDTH is 8).
REQ-003 clk  input  1  Single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  Reset, asynchronous and active-low.
REQ-005 in_valid  input  1  Request present.
REQ-006 in_ready  output  1  Unit can accept a request.
REQ-007 in_data  input  WIDTH  Operand.
REQ-008 in_op  input  2  Operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-009 in_amt  input  AW  Shift amount, 0..WIDTH-1.
REQ-010 out_valid  output  1  Result present.
REQ-011 out_ready  input  1  Consumer accepts the result.
REQ-012 out_data  output  WIDTH  Result.
REQ-013 busy  output  1  High whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL equal (state == IDLE); a request is accepted on an edge where in_valid and in_ready are both high.
REQ-016 On accept, the unit SHALL capture in_data into the working register, in_op into the op register and in_amt into the counter.
- Next state: SHIFT if in_amt != 0, otherwise DONE.
REQ-017 In SHIFT, each cycle SHALL apply a one-bit shift of the held op to the working register and decrement the counter.
- The state moves to DONE on the cycle the counter goes from 1 to 0.
REQ-018 One-bit shift rules:
- SLL inserts 0 at the LSB.
- SRL inserts 0 at the MSB.
- SRA replicates the MSB.
- ROL moves the MSB into the LSB.
REQ-019 out_valid SHALL equal (state == DONE), and out_data SHALL always equal the working register.
REQ-020 In DONE, the state SHALL go to IDLE on out_ready; while out_ready is low, out_data and out_valid SHALL hold stable.
REQ-021 Latency SHALL be in_amt + 1 cycles from the accept edge to the first cycle with out_valid high.
REQ-022 There SHALL be no overlap between requests: while busy is high, in_valid is ignored and in_data changes have no effect.
REQ-023 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-024 While rst_n is low, the unit SHALL immediately show state IDLE, working register 0, counter 0 and op register 00.
- Output values: in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-025 A reset asserted during SHIFT or DONE SHALL abort the operation.
- No out_valid pulse follows deassertion.
- The first cycle after deassertion accepts a new request.

Configuration
REQ-026 With macro SHIFT_FAST_EN defined, the SHIFT state SHALL never be entered.
- On accept, the full shift is computed combinationally through an AW-stage log shifter and registered.
- The state goes directly to DONE, so latency is always 1 cycle.
REQ-027 Without SHIFT_FAST_EN, only the iterative one-bit datapath SHALL exist, giving in_amt + 1 cycle latency.
REQ-028 Results SHALL be identical in both builds.

Structure
REQ-029 Package shift_seq_pkg SHALL hold:
- the op encoding constants OP_SLL, OP_SRL, OP_SRA, OP_ROL;
- the FSM state typedef.
REQ-030 The per-bit next-value selection SHALL use sub-module mux4_1: four 1-bit data inputs, a 2-bit select and one output, purely combinational, instantiated WIDTH times with select = op register.

Verification
REQ-031 Accept 0x96, SRA, amt 3 -> out_valid high 4 cycles after accept with out_data 0xF2.
REQ-032 Accept 0x81, ROL, amt 4 -> out_data 0x18; separately, 0x80 SRL amt 7 -> out_data 0x01 after 8 cycles.
REQ-033 Accept 0x5A, any op, amt 0 -> out_valid high the next cycle with out_data 0x5A.
REQ-034 Hold out_ready low 5 cycles in DONE -> out_data stays stable and in_ready stays 0; raise out_ready -> IDLE, with in_ready high the next cycle.
REQ-035 Assert rst_n low mid-SHIFT on 0x81 SLL amt 6 -> outputs immediately show reset values, and no out_valid follows; then 0x81 SLL amt 1 -> out_data 0x02.
REQ-036 Toggle in_valid and in_data while busy -> the result is unaffected and no second result is produced.
